instr_mem: RTL and testbench

INSTR_MEM -- requirements
Module: instr_mem

---
 rtl/imem_pkg.sv | 26 ++
 rtl/imem_array.sv | 30 +++
 rtl/instr_mem.sv | 130 +++++++++++++
 tb/tb_instr_mem.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory: FSM states, the NOP
// fill word, RV32I opcode constants, and the fetch address fault rule.
package imem_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6f;

    // addi x0,x0,0
    localparam logic [31:0] NOP_WORD = {25'd0, OPC_OP_IMM};

    // Misaligned or beyond the array; the full upper address is compared so
    // high bits can never alias onto a valid word.
    function automatic logic addr_fault(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || (32'(addr[31:2]) >= depth);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Word-wide instruction storage: one write port, one registered read port.
// Contents are never reset; they start out as the fill word.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] INIT_WORD = NOP_WORD,
    parameter int          AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH] = '{default: INIT_WORD};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_mem.sv
// Instruction memory with a byte-serial boot loader (LOAD) and a latency-1
// fetch port with response hold and address fault reporting (RUN).
module instr_mem #(
    parameter int unsigned DEPTH     = 64,
    parameter bit          BOOT_LOAD = 1'b1,
    parameter logic [31:0] NOP_WORD  = imem_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_fault,
    input  logic        rsp_stall,
    input  logic        prog_valid,
    input  logic [7:0]  prog_byte,
    input  logic        prog_last,
    output logic        prog_ready,
    input  logic        prog_start,
    output logic        loading
);
    import imem_pkg::*;

    localparam int AW = $clog2(DEPTH);

    state_t        state;
    logic [AW-1:0] wcnt;
    logic [1:0]    bcnt;
    logic [23:0]   byte_buf;
    logic          start_pend;

    logic          accept;
    logic          fetch_fault;
    logic          prog_fire;
    logic          word_wr;
    logic          last_word;
    logic          start_req;
    logic [31:0]   wr_word;
    logic [31:0]   rd_word;

    assign loading     = (state == LOAD);
    assign prog_ready  = (state == LOAD);
    assign fetch_ready = (state == RUN) && !(rsp_valid && rsp_stall);

    assign accept      = fetch_req && fetch_ready;
    assign fetch_fault = addr_fault(fetch_addr, DEPTH);
    assign prog_fire   = (state == LOAD) && prog_valid;
    assign word_wr     = prog_fire && ((bcnt == 2'd3) || prog_last);
    assign last_word   = (wcnt == AW'(DEPTH - 1));
    assign start_req   = prog_start || start_pend;

    // Lanes above the current byte are still zero, which zero-fills a short final word.
    assign wr_word = {8'h00, byte_buf} | ({24'h0, prog_byte} << {bcnt, 3'b000});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BOOT_LOAD ? LOAD : RUN;
            wcnt       <= '0;
            bcnt       <= '0;
            byte_buf   <= '0;
            start_pend <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (prog_fire) begin
                        if (word_wr) begin
                            wcnt     <= wcnt + 1'b1;
                            bcnt     <= '0;
                            byte_buf <= '0;
                            if (prog_last || last_word) begin
                                state <= RUN;
                            end
                        end else begin
                            bcnt     <= bcnt + 1'b1;
                            byte_buf <= byte_buf | ({16'h0, prog_byte} << {bcnt, 3'b000});
                        end
                    end
                end
                RUN: begin
                    // A reload request waits until the outstanding response is gone.
                    if (start_req) begin
                        if (!rsp_valid) begin
                            state      <= LOAD;
                            wcnt       <= '0;
                            bcnt       <= '0;
                            byte_buf   <= '0;
                            start_pend <= 1'b0;
                        end else begin
                            start_pend <= 1'b1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_fault <= fetch_fault;
        end else if (!rsp_stall) begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
        end
    end

    imem_array #(
        .DEPTH     (DEPTH),
        .INIT_WORD (NOP_WORD),
        .AW        (AW)
    ) u_array (
        .clk   (clk),
        .we    (word_wr),
        .waddr (wcnt),
        .wdata (wr_word),
        .re    (accept && !fetch_fault),
        .raddr (fetch_addr[AW+1:2]),
        .rdata (rd_word)
    );

    // The read register only updates on a clean accept, so it holds through a stall.
    assign rsp_data = (rsp_valid && !rsp_fault) ? rd_word : NOP_WORD;

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: directed boot/fault/stall/reload scenarios
// plus randomized fetch traffic checked against a word-array reference model.
module tb_instr_mem;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    logic        rsp_stall;
    logic        prog_valid;
    logic [7:0]  prog_byte;
    logic        prog_last;
    logic        prog_ready;
    logic        prog_start;
    logic        loading;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];
    logic [7:0]  ld_q [$];

    instr_mem #(
        .DEPTH     (DEPTH),
        .BOOT_LOAD (1'b1),
        .NOP_WORD  (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_fault   (rsp_fault),
        .rsp_stall   (rsp_stall),
        .prog_valid  (prog_valid),
        .prog_byte   (prog_byte),
        .prog_last   (prog_last),
        .prog_ready  (prog_ready),
        .prog_start  (prog_start),
        .loading     (loading)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_fault(input logic [31:0] addr);
        return (addr % 4 != 0) || ((addr / 4) >= DEPTH);
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] addr);
        if (exp_fault(addr)) return NOP;
        return model_mem[addr / 4];
    endfunction

    // Streams ld_q into the loader; the model writes a word every 4 bytes or on last.
    task automatic load_q(input bit last, input bit exp_done);
        logic [31:0] mw;
        mw = '0;
        for (int i = 0; i < ld_q.size(); i++) begin
            prog_valid = 1'b1;
            prog_byte  = ld_q[i];
            prog_last  = last && (i == ld_q.size() - 1);
            #1;
            checks++;
            if (prog_ready !== 1'b1 || loading !== 1'b1 || fetch_ready !== 1'b0) begin
                failures++;
                $display("FAIL load_hs byte %0d: prog_ready=%b loading=%b fetch_ready=%b want 1 1 0",
                         i, prog_ready, loading, fetch_ready);
            end
            if (i % 4 == 0) mw = '0;
            mw = mw | (32'(ld_q[i]) << (8 * (i % 4)));
            if ((i % 4 == 3) || prog_last) model_mem[i / 4] = mw;
            tick();
        end
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        checks++;
        if (loading !== !exp_done) begin
            failures++;
            $display("FAIL load_end: loading=%b want %b", loading, !exp_done);
        end
    endtask

    task automatic fetch_one(input logic [31:0] addr, input string name);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        #1;
        checks++;
        if (fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready: got %b want 1", name, fetch_ready);
        end
        tick();
        fetch_req = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_fault !== exp_fault(addr) || rsp_data !== exp_data(addr)) begin
            failures++;
            $display("FAIL %s addr %h: valid=%b fault=%b data=%h want 1 %b %h",
                     name, addr, rsp_valid, rsp_fault, rsp_data, exp_fault(addr), exp_data(addr));
        end
    endtask

    task automatic enter_load();
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
        checks++;
        if (loading !== 1'b1) begin
            failures++;
            $display("FAIL enter_load: loading=%b want 1", loading);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if (loading !== 1'b1 || prog_ready !== 1'b1 || fetch_ready !== 1'b0 ||
            rsp_valid !== 1'b0 || rsp_data !== NOP || rsp_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: load=%b pr=%b fr=%b v=%b d=%h f=%b want 1 1 0 0 %h 0",
                     loading, prog_ready, fetch_ready, rsp_valid, rsp_data, rsp_fault, NOP);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_boot();
        ld_q = '{8'h13, 8'h02, 8'h10, 8'h00, 8'h93, 8'h02, 8'h20, 8'h00};
        load_q(1'b1, 1'b1);
        // back-to-back fetch of word 0 then word 1
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        tick();
        fetch_addr = 32'h4;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0010_0213 || rsp_fault !== 1'b0) begin
            failures++;
            $display("FAIL boot_w0: valid=%b data=%h fault=%b want 1 00100213 0", rsp_valid, rsp_data, rsp_fault);
        end
        tick();
        fetch_req = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0020_0293 || rsp_fault !== 1'b0) begin
            failures++;
            $display("FAIL boot_w1: valid=%b data=%h fault=%b want 1 00200293 0", rsp_valid, rsp_data, rsp_fault);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL boot_drain: rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_fault();
        fetch_one(32'h2, "fault_misalign");
        checks++;
        if (rsp_fault !== 1'b1 || rsp_data !== 32'h0000_0013) begin
            failures++;
            $display("FAIL fault_misalign_const: fault=%b data=%h want 1 00000013", rsp_fault, rsp_data);
        end
        fetch_one(4 * DEPTH, "fault_range");
        fetch_one(32'h8000_0004, "fault_high");
        fetch_one(32'h4, "fault_recover");
        for (int i = 0; i < 6; i++) begin
            fetch_one($urandom, "fault_rand");
        end
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] held;
        fetch_one(32'h0, "stall_first");
        held       = rsp_data;
        rsp_stall  = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (fetch_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== held || held !== model_mem[0]) begin
                failures++;
                $display("FAIL stall_hold cyc %0d: ready=%b valid=%b data=%h want 0 1 %h",
                         i, fetch_ready, rsp_valid, rsp_data, model_mem[0]);
            end
            tick();
        end
        rsp_stall = 1'b0;
        #1;
        checks++;
        if (fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: ready=%b want 1", fetch_ready);
        end
        tick();
        fetch_req = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== model_mem[1]) begin
            failures++;
            $display("FAIL stall_next: valid=%b data=%h want 1 %h", rsp_valid, rsp_data, model_mem[1]);
        end
        tick();
    endtask

    // Random requests, addresses and stalls against a transaction-level model.
    task automatic test_back_to_back(input int cycles);
        logic        m_valid, m_fault, exp_ready, req;
        logic [31:0] m_data, addr;
        m_valid = rsp_valid;
        m_fault = 1'b0;
        m_data  = NOP;
        for (int c = 0; c < cycles; c++) begin
            req  = ($urandom_range(0, 3) != 0);
            addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1)) * 4;
            fetch_req  = req;
            fetch_addr = addr;
            rsp_stall  = ($urandom_range(0, 3) == 0);
            exp_ready  = !(m_valid && rsp_stall);
            #1;
            checks++;
            if (fetch_ready !== exp_ready) begin
                failures++;
                $display("FAIL b2b_ready cyc %0d: got %b want %b", c, fetch_ready, exp_ready);
            end
            tick();
            if (req && exp_ready) begin
                m_valid = 1'b1;
                m_fault = exp_fault(addr);
                m_data  = exp_data(addr);
            end else if (!rsp_stall) begin
                m_valid = 1'b0;
            end
            checks++;
            if (rsp_valid !== m_valid || (m_valid && (rsp_data !== m_data || rsp_fault !== m_fault))) begin
                failures++;
                $display("FAIL b2b_rsp cyc %0d: valid=%b data=%h fault=%b want %b %h %b",
                         c, rsp_valid, rsp_data, rsp_fault, m_valid, m_data, m_fault);
            end
        end
        fetch_req = 1'b0;
        rsp_stall = 1'b0;
        tick();
    endtask

    task automatic test_partial();
        enter_load();
        ld_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
        load_q(1'b1, 1'b1);
        fetch_one(32'h4, "partial_w1");
        checks++;
        if (rsp_data !== 32'h0000_0011) begin
            failures++;
            $display("FAIL partial_const: data=%h want 00000011", rsp_data);
        end
        fetch_one(32'h0, "partial_w0");
        tick();
    endtask

    task automatic test_full();
        enter_load();
        ld_q.delete();
        for (int i = 0; i < DEPTH * 4; i++) ld_q.push_back(8'($urandom));
        load_q(1'b0, 1'b1);
        fetch_one(4 * (DEPTH - 1), "full_last");
        fetch_one(32'h0, "full_first");
        for (int i = 0; i < 4; i++) fetch_one(32'($urandom_range(0, DEPTH - 1)) * 4, "full_rand");
        tick();
    endtask

    task automatic test_start_stall();
        fetch_one(32'h8, "ss_fetch");
        rsp_stall  = 1'b1;
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (loading !== 1'b0 || rsp_valid !== 1'b1) begin
                failures++;
                $display("FAIL ss_deferred cyc %0d: loading=%b valid=%b want 0 1", i, loading, rsp_valid);
            end
            tick();
        end
        rsp_stall = 1'b0;
        tick();
        checks++;
        if (loading !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL ss_release: loading=%b valid=%b want 0 0", loading, rsp_valid);
        end
        tick();
        checks++;
        if (loading !== 1'b1) begin
            failures++;
            $display("FAIL ss_enter: loading=%b want 1", loading);
        end
    endtask

    task automatic test_reset_midload();
        ld_q.delete();
        for (int i = 0; i < 6; i++) ld_q.push_back(8'($urandom));
        load_q(1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        tick();
        // A stale partial word would corrupt these lanes if it survived reset.
        ld_q.delete();
        for (int i = 0; i < 4; i++) ld_q.push_back(8'($urandom));
        load_q(1'b1, 1'b1);
        fetch_one(32'h0, "rml_w0");
        fetch_one(32'h4, "rml_w1");
        fetch_one(32'h14, "rml_w5");
        tick();
    endtask

    task automatic test_reset_pending();
        fetch_one(32'h0, "rp_fetch");
        rsp_stall = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== NOP || rsp_fault !== 1'b0 || loading !== 1'b1) begin
            failures++;
            $display("FAIL reset_pending: valid=%b data=%h fault=%b loading=%b want 0 %h 0 1",
                     rsp_valid, rsp_data, rsp_fault, loading, NOP);
        end
        tick();
        reset     = 1'b0;
        rsp_stall = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
        reset      = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        rsp_stall  = 1'b0;
        prog_valid = 1'b0;
        prog_byte  = '0;
        prog_last  = 1'b0;
        prog_start = 1'b0;

        test_reset();
        test_boot();
        test_fault();
        test_stall();
        test_back_to_back(40);
        test_partial();
        test_full();
        test_back_to_back(60);
        test_start_stall();
        test_reset_midload();
        test_reset_pending();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
